cam_capture_rgb332: RTL



---
 rtl/cam_capture_rgb332.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cam_capture_rgb332.sv
// rtl/cam_capture_rgb332.sv - OV7670 byte capture, RGB565->RGB332 packing and frame-buffer write port
//
// Purpose: frames camera bytes with vsync/href, packs RGB565 byte pairs into
// RGB332 and issues one registered write per stored pixel, clipping anything
// outside CAM_SCREEN_X x CAM_SCREEN_Y. Everything runs on the pixel clock.
//
// Ports:
//   clk          camera pixel clock, rising edge
//   rst          asynchronous active-low reset
//   vsync        camera VSYNC, high = vertical blanking
//   href         camera HREF, high = valid byte on px_data
//   px_data      camera data byte
//   mem_px_addr  linear write address (y*CAM_SCREEN_X + x), held while idle
//   mem_px_data  RGB332 pixel
//   px_wr        one-cycle write strobe per stored pixel
//   frame_done   one-cycle pulse after the vsync rise that ends a frame
//   frame_cnt    completed-frame counter, wraps 255->0
module cam_capture_rgb332 #(
  parameter int AW           = 17,
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic [7:0]    frame_cnt
);

  // Counters are one value wider than the visible range so they can park at
  // the limit instead of wrapping back into the stored area.
  localparam int XW = $clog2(CAM_SCREEN_X + 1);
  localparam int YW = $clog2(CAM_SCREEN_Y + 1);
  localparam logic [XW-1:0] LP_X_MAX     = XW'(CAM_SCREEN_X);
  localparam logic [YW-1:0] LP_Y_MAX     = YW'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] LP_LINE_STEP = AW'(CAM_SCREEN_X);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    CAPTURE    = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_vsync_q;
  logic          r_href_q;
  logic          r_phase;
  logic [5:0]    r_byte1;      // only the bits that survive packing: {R[4:2], G[5:3]}
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_line_base;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_px_data;
  logic          r_px_wr;
  logic          r_frame_done;
  logic [7:0]    r_frame_cnt;

  logic       w_vs_fall;
  logic       w_vs_rise;
  logic       w_href_fall;
  logic       w_byte_en;
  logic       w_pix_keep;
  logic [7:0] w_pixel;

  assign w_vs_fall   = r_vsync_q & ~vsync;
  assign w_vs_rise   = ~r_vsync_q & vsync;
  assign w_href_fall = r_href_q & ~href;
  // href during blanking is never treated as pixel data
  assign w_byte_en   = href & ~vsync;
  assign w_pix_keep  = (r_x < LP_X_MAX) && (r_y < LP_Y_MAX);
  assign w_pixel     = {r_byte1, px_data[4:3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT_FRAME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_FRAME: if (w_vs_fall) w_state_nxt = CAPTURE;
      CAPTURE:    if (w_vs_rise) w_state_nxt = WAIT_FRAME;
      default:    w_state_nxt = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vsync_q    <= 1'b0;
      r_href_q     <= 1'b0;
      r_phase      <= 1'b0;
      r_byte1      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_line_base  <= '0;
      r_addr       <= '0;
      r_px_data    <= '0;
      r_px_wr      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_vsync_q    <= vsync;
      r_href_q     <= href;
      r_px_wr      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT_FRAME: begin
          if (w_vs_fall) begin
            r_x         <= '0;
            r_y         <= '0;
            r_phase     <= 1'b0;
            r_line_base <= '0;
            r_addr      <= '0;
          end
        end
        CAPTURE: begin
          if (w_byte_en) begin
            if (!r_phase) begin
              r_byte1 <= {px_data[7:5], px_data[2:0]};
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (w_pix_keep) begin
                r_px_wr   <= 1'b1;
                r_px_data <= w_pixel;
                r_addr    <= r_line_base + AW'(r_x);
              end
              if (r_x != LP_X_MAX) r_x <= r_x + XW'(1);
            end
          end else if (w_href_fall) begin
            // end of line: an unpaired trailing byte is simply dropped
            r_x     <= '0;
            r_phase <= 1'b0;
            if (r_y != LP_Y_MAX) begin
              r_y         <= r_y + YW'(1);
              r_line_base <= r_line_base + LP_LINE_STEP;
            end
          end
          if (w_vs_rise) begin
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_px_addr = r_addr;
  assign mem_px_data = r_px_data;
  assign px_wr       = r_px_wr;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;

endmodule
